// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: requester ids, FSM states,
// UART store addresses and access-width codes.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  localparam logic [31:0] UART_TX_ADDR   = 32'h0003_0000;
  localparam logic [31:0] UART_STAT_ADDR = 32'h0003_0004;

  localparam logic [2:0] WIDTH_BYTE = 3'd0;
  localparam logic [2:0] WIDTH_HALF = 3'd1;
  localparam logic [2:0] WIDTH_WORD = 3'd2;

  // Round-robin successor: IF -> LD -> ST -> IF.
  function automatic owner_e next_owner(input owner_e o);
    case (o)
      OWN_IF:  return OWN_LD;
      OWN_LD:  return OWN_ST;
      default: return OWN_IF;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and controller signals of the memory arbiter.
// master = arbiter side, slave = requesters plus memory controller.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 2
);

  logic                      io_buffer_full;

  logic                      IF_en;
  logic [ADDR_WIDTH-1:0]     IF_addr;
  logic                      IF_done;
  logic [32*BLOCK_SIZE-1:0]  IF_block;

  logic                      LD_en;
  logic [ADDR_WIDTH-1:0]     LD_addr;
  logic [2:0]                LD_width;
  logic                      LD_done;
  logic [31:0]               LD_data;

  logic                      ST_en;
  logic [ADDR_WIDTH-1:0]     ST_addr;
  logic [2:0]                ST_width;
  logic [31:0]               ST_data;
  logic                      ST_done;

  logic                      AMC_en;
  logic                      AMC_wr;
  logic [2:0]                AMC_width;
  logic [ADDR_WIDTH-1:0]     AMC_addr;
  logic [31:0]               AMC_data;
  logic                      AMC_fetch;

  logic                      MCA_r_en;
  logic                      MCA_w_en;
  logic [31:0]               MCA_data;
  logic [32*BLOCK_SIZE-1:0]  MCA_block;

  modport master (
    input  io_buffer_full,
    input  IF_en, IF_addr, LD_en, LD_addr, LD_width,
    input  ST_en, ST_addr, ST_width, ST_data,
    input  MCA_r_en, MCA_w_en, MCA_data, MCA_block,
    output IF_done, IF_block, LD_done, LD_data, ST_done,
    output AMC_en, AMC_wr, AMC_width, AMC_addr, AMC_data, AMC_fetch
  );

  modport slave (
    output io_buffer_full,
    output IF_en, IF_addr, LD_en, LD_addr, LD_width,
    output ST_en, ST_addr, ST_width, ST_data,
    output MCA_r_en, MCA_w_en, MCA_data, MCA_block,
    input  IF_done, IF_block, LD_done, LD_data, ST_done,
    input  AMC_en, AMC_wr, AMC_width, AMC_addr, AMC_data, AMC_fetch
  );

endinterface

// File: rtl/mem_arbiter_rr_pick3.sv
// Three-way round-robin picker: highest priority is the requester after
// last_i, last_i itself is lowest. Purely combinational.
module mem_arbiter_rr_pick3
  import mem_arbiter_pkg::*;
(
  input  logic [2:0] elig_i,
  input  owner_e     last_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  owner_e pri0;
  owner_e pri1;

  always_comb begin
    pri0  = next_owner(last_i);
    pri1  = next_owner(pri0);
    gnt_o = 3'b000;
    if (elig_i[pri0]) begin
      gnt_o[pri0] = 1'b1;
    end else if (elig_i[pri1]) begin
      gnt_o[pri1] = 1'b1;
    end else if (elig_i[last_i]) begin
      gnt_o[last_i] = 1'b1;
    end
    valid_o = |gnt_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the memory controller between fetch, load and
// store; skips UART stores while the UART buffer is full.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_IDLE    | AMC_en=0, pick an eligible requester and latch its request
//   S_GRANT   | AMC_* held, wait for the owner's controller done pulse
//   S_RELEASE | one idle cycle so the controller can clear its done flag
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int BLOCK_WIDTH = 1,
  localparam int BLOCK_SIZE  = 1 << BLOCK_WIDTH
) (
  input  logic          Sys_clk,
  input  logic          Sys_rst,
  input  logic          Sys_rdy,
  mem_arbiter_if.master bus
);

  state_e                    state_q;
  owner_e                    rr_ptr_q;
  owner_e                    owner_q;
  logic                      fresh_q;
  logic                      drop_q;
  logic                      amc_en_q;
  logic                      amc_wr_q;
  logic                      amc_fetch_q;
  logic [2:0]                amc_width_q;
  logic [ADDR_WIDTH-1:0]     amc_addr_q;
  logic [31:0]               amc_data_q;
  logic                      if_done_q;
  logic                      ld_done_q;
  logic                      st_done_q;
  logic [32*BLOCK_SIZE-1:0]  if_block_q;
  logic [31:0]               ld_data_q;

  logic       uart_stall;
  logic [2:0] elig;
  logic [2:0] gnt;
  logic       gnt_valid;
  owner_e     gnt_owner;
  owner_e     last_owner;
  logic       owner_en;
  logic       mca_done;

  assign uart_stall = bus.io_buffer_full &&
                      ((bus.ST_addr == ADDR_WIDTH'(UART_TX_ADDR)) ||
                       (bus.ST_addr == ADDR_WIDTH'(UART_STAT_ADDR)));

  assign elig = {bus.ST_en && !uart_stall, bus.LD_en, bus.IF_en};

  // Until the first grant after reset, IF holds top priority.
  assign last_owner = fresh_q ? OWN_ST : rr_ptr_q;

  mem_arbiter_rr_pick3 u_pick (
    .elig_i  (elig),
    .last_i  (last_owner),
    .gnt_o   (gnt),
    .valid_o (gnt_valid)
  );

  always_comb begin
    gnt_owner = OWN_IF;
    if (gnt[1]) begin
      gnt_owner = OWN_LD;
    end else if (gnt[2]) begin
      gnt_owner = OWN_ST;
    end
  end

  always_comb begin
    case (owner_q)
      OWN_LD:  owner_en = bus.LD_en;
      OWN_ST:  owner_en = bus.ST_en;
      default: owner_en = bus.IF_en;
    endcase
  end

  assign mca_done = (owner_q == OWN_ST) ? bus.MCA_w_en : bus.MCA_r_en;

  always_ff @(posedge Sys_clk) begin
    if (Sys_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= OWN_IF;
      owner_q     <= OWN_IF;
      fresh_q     <= 1'b1;
      drop_q      <= 1'b0;
      amc_en_q    <= 1'b0;
      amc_wr_q    <= 1'b0;
      amc_fetch_q <= 1'b0;
      amc_width_q <= '0;
      amc_addr_q  <= '0;
      amc_data_q  <= '0;
      if_done_q   <= 1'b0;
      ld_done_q   <= 1'b0;
      st_done_q   <= 1'b0;
      if_block_q  <= '0;
      ld_data_q   <= '0;
    end else if (Sys_rdy) begin
      if_done_q <= 1'b0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (gnt_valid) begin
            state_q     <= S_GRANT;
            owner_q     <= gnt_owner;
            rr_ptr_q    <= gnt_owner;
            fresh_q     <= 1'b0;
            drop_q      <= 1'b0;
            amc_en_q    <= 1'b1;
            amc_wr_q    <= (gnt_owner == OWN_ST);
            amc_fetch_q <= (gnt_owner == OWN_IF);
            case (gnt_owner)
              OWN_LD: begin
                amc_addr_q  <= bus.LD_addr;
                amc_width_q <= bus.LD_width;
                amc_data_q  <= '0;
              end
              OWN_ST: begin
                amc_addr_q  <= bus.ST_addr;
                amc_width_q <= bus.ST_width;
                amc_data_q  <= bus.ST_data;
              end
              default: begin
                amc_addr_q  <= bus.IF_addr;
                amc_width_q <= WIDTH_BYTE;
                amc_data_q  <= '0;
              end
            endcase
          end
        end
        S_GRANT: begin
          // An owner that lets go mid-transaction gets neither done nor data.
          if (!owner_en) begin
            drop_q <= 1'b1;
          end
          if (mca_done) begin
            amc_en_q <= 1'b0;
            state_q  <= S_RELEASE;
            if (owner_en && !drop_q) begin
              case (owner_q)
                OWN_LD: begin
                  ld_done_q <= 1'b1;
                  ld_data_q <= bus.MCA_data;
                end
                OWN_ST: st_done_q <= 1'b1;
                default: begin
                  if_done_q  <= 1'b1;
                  if_block_q <= bus.MCA_block;
                end
              endcase
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.AMC_en    = amc_en_q;
  assign bus.AMC_wr    = amc_wr_q;
  assign bus.AMC_fetch = amc_fetch_q;
  assign bus.AMC_width = amc_width_q;
  assign bus.AMC_addr  = amc_addr_q;
  assign bus.AMC_data  = amc_data_q;
  assign bus.IF_block  = if_block_q;
  assign bus.LD_data   = ld_data_q;

  // A pending done held across a stall is shown once Sys_rdy returns.
  assign bus.IF_done = if_done_q & Sys_rdy;
  assign bus.LD_done = ld_done_q & Sys_rdy;
  assign bus.ST_done = st_done_q & Sys_rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with a done-pulse
// scoreboard fed when each controller response is driven.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic Sys_clk = 1'b0;
  logic Sys_rst = 1'b1;
  logic Sys_rdy = 1'b1;

  mem_arbiter_if #(.ADDR_WIDTH(32), .BLOCK_SIZE(2)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .BLOCK_WIDTH(1)) dut (
    .Sys_clk (Sys_clk),
    .Sys_rst (Sys_rst),
    .Sys_rdy (Sys_rdy),
    .bus     (bus)
  );

  always #5 Sys_clk = ~Sys_clk;

  int cyc = 0;
  always @(posedge Sys_clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int grant_cyc = 0;
  int done_cyc  = 0;

  typedef struct {
    logic [1:0]  who;
    logic [63:0] val;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dones();
    return 64'({bus.ST_done, bus.LD_done, bus.IF_done});
  endfunction

  // Scoreboard: every done pulse must match the oldest expected completion.
  exp_t mon_e;
  always @(negedge Sys_clk) begin
    if (|dones() === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", dones(), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_who", dones(), 64'd1 << mon_e.who);
        if (mon_e.who == 2'd0) chk("if_block", bus.IF_block, mon_e.val);
        if (mon_e.who == 2'd1) chk("ld_data", 64'(bus.LD_data), mon_e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.io_buffer_full = 1'b0;
    bus.IF_en = 1'b0; bus.IF_addr = '0;
    bus.LD_en = 1'b0; bus.LD_addr = '0; bus.LD_width = '0;
    bus.ST_en = 1'b0; bus.ST_addr = '0; bus.ST_width = '0; bus.ST_data = '0;
    bus.MCA_r_en = 1'b0; bus.MCA_w_en = 1'b0; bus.MCA_data = '0; bus.MCA_block = '0;
    Sys_rdy = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    Sys_rst = 1'b1;
    repeat (2) @(negedge Sys_clk);
    chk("rst_amc_en", 64'(bus.AMC_en), 64'd0);
    chk("rst_amc_addr", 64'(bus.AMC_addr), 64'd0);
    chk("rst_if_block", bus.IF_block, 64'd0);
    chk("rst_ld_data", 64'(bus.LD_data), 64'd0);
    chk("rst_dones", dones(), 64'd0);
    Sys_rst = 1'b0;
  endtask

  task automatic wait_grant(output bit ok);
    int n = 0;
    while (bus.AMC_en !== 1'b1 && n < 50) begin
      @(negedge Sys_clk);
      n++;
    end
    ok = (bus.AMC_en === 1'b1);
    if (!ok) chk("grant_timeout", 64'(bus.AMC_en), 64'd1);
    grant_cyc = cyc;
  endtask

  // Acts as the controller for one transaction; a wrong-type pulse comes first.
  task automatic serve(input logic [1:0] who, input logic [31:0] addr, input logic [2:0] width,
                       input logic [31:0] sdata, input logic [63:0] resp, input bit exp_done);
    bit ok;
    exp_t e;
    wait_grant(ok);
    if (!ok) return;
    chk("amc_fetch", 64'(bus.AMC_fetch), 64'(who == 2'd0));
    chk("amc_wr", 64'(bus.AMC_wr), 64'(who == 2'd2));
    chk("amc_addr", 64'(bus.AMC_addr), 64'(addr));
    chk("amc_width", 64'(bus.AMC_width), (who == 2'd0) ? 64'd0 : 64'(width));
    chk("amc_data", 64'(bus.AMC_data), (who == 2'd2) ? 64'(sdata) : 64'd0);
    if (who == 2'd2) bus.MCA_r_en = 1'b1; else bus.MCA_w_en = 1'b1;
    @(negedge Sys_clk);
    bus.MCA_r_en = 1'b0; bus.MCA_w_en = 1'b0;
    chk("amc_hold", 64'(bus.AMC_en), 64'd1);
    chk("no_early_done", dones(), 64'd0);
    if (exp_done) begin
      e.who = who; e.val = resp;
      exp_q.push_back(e);
    end
    bus.MCA_data = resp[31:0];
    bus.MCA_block = resp;
    if (who == 2'd2) bus.MCA_w_en = 1'b1; else bus.MCA_r_en = 1'b1;
    @(negedge Sys_clk);
    bus.MCA_r_en = 1'b0; bus.MCA_w_en = 1'b0;
    chk("done_latency", 64'(dones()[who]), 64'(exp_done));
    chk("amc_release", 64'(bus.AMC_en), 64'd0);
    done_cyc = cyc;
  endtask

  initial begin
    bit ok;
    int prev;
    int t;
    exp_t e;
    clear_inputs();
    do_reset();

    // 1: single load
    bus.LD_en = 1'b1; bus.LD_addr = 32'h100; bus.LD_width = 3'd2;
    serve(2'd1, 32'h100, 3'd2, 32'h0, 64'h0000_0000_DEAD_BEEF, 1'b1);
    bus.LD_en = 1'b0;
    @(negedge Sys_clk);
    chk("t1_ld_data_hold", 64'(bus.LD_data), 64'hDEAD_BEEF);
    chk("t1_release_low", 64'(bus.AMC_en), 64'd0);

    // 2: all three held from reset
    do_reset();
    bus.IF_en = 1'b1; bus.IF_addr = 32'h200;
    bus.LD_en = 1'b1; bus.LD_addr = 32'h104; bus.LD_width = 3'd1;
    bus.ST_en = 1'b1; bus.ST_addr = 32'h400; bus.ST_width = 3'd2; bus.ST_data = 32'hCAFE_F00D;
    serve(2'd0, 32'h200, 3'd0, 32'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
    prev = done_cyc;
    serve(2'd1, 32'h104, 3'd1, 32'h0, 64'h0000_0000_5555_AAAA, 1'b1);
    chk("t2_gap_ld", 64'(grant_cyc - prev), 64'd2);
    prev = done_cyc;
    serve(2'd2, 32'h400, 3'd2, 32'hCAFE_F00D, 64'h0, 1'b1);
    chk("t2_gap_st", 64'(grant_cyc - prev), 64'd2);
    prev = done_cyc;
    serve(2'd0, 32'h200, 3'd0, 32'h0, 64'hFEDC_BA98_7654_3210, 1'b1);
    chk("t2_gap_if", 64'(grant_cyc - prev), 64'd2);
    bus.IF_en = 1'b0; bus.LD_en = 1'b0; bus.ST_en = 1'b0;

    // 3: stalled UART store is skipped, not blocking
    do_reset();
    bus.io_buffer_full = 1'b1;
    bus.ST_en = 1'b1; bus.ST_addr = 32'h30000; bus.ST_width = 3'd0; bus.ST_data = 32'h41;
    bus.LD_en = 1'b1; bus.LD_addr = 32'h108; bus.LD_width = 3'd0;
    serve(2'd1, 32'h108, 3'd0, 32'h0, 64'h0000_0000_0000_00A5, 1'b1);
    bus.LD_en = 1'b0;
    repeat (4) begin
      @(negedge Sys_clk);
      chk("t3_stalled", 64'(bus.AMC_en), 64'd0);
    end
    bus.io_buffer_full = 1'b0;
    t = cyc;
    serve(2'd2, 32'h30000, 3'd0, 32'h41, 64'h0, 1'b1);
    chk("t3_st_first_idle", 64'(grant_cyc - t), 64'd1);
    bus.ST_addr = 32'h30008; bus.ST_data = 32'h42; bus.io_buffer_full = 1'b1;
    serve(2'd2, 32'h30008, 3'd0, 32'h42, 64'h0, 1'b1);
    bus.ST_addr = 32'h30004;
    repeat (3) begin
      @(negedge Sys_clk);
      chk("t3_stalled_30004", 64'(bus.AMC_en), 64'd0);
    end
    bus.ST_en = 1'b0; bus.io_buffer_full = 1'b0;

    // 4: fetch abandoned during GRANT
    bus.IF_en = 1'b1; bus.IF_addr = 32'h800;
    serve(2'd0, 32'h800, 3'd0, 32'h0, 64'h1111_2222_3333_4444, 1'b1);
    bus.IF_en = 1'b0;
    @(negedge Sys_clk);
    bus.IF_en = 1'b1;
    wait_grant(ok);
    bus.IF_en = 1'b0;
    @(negedge Sys_clk);
    bus.MCA_block = 64'h9999_8888_7777_6666; bus.MCA_r_en = 1'b1;
    @(negedge Sys_clk);
    bus.MCA_r_en = 1'b0;
    chk("t4_if_done", 64'(bus.IF_done), 64'd0);
    chk("t4_amc_off", 64'(bus.AMC_en), 64'd0);
    @(negedge Sys_clk);
    chk("t4_if_block", bus.IF_block, 64'h1111_2222_3333_4444);
    bus.LD_en = 1'b1; bus.LD_addr = 32'h10C; bus.LD_width = 3'd2;
    serve(2'd1, 32'h10C, 3'd2, 32'h0, 64'h0000_0000_1234_5678, 1'b1);
    bus.LD_en = 1'b0;

    // 5: reset collides with the store's write-done
    bus.ST_en = 1'b1; bus.ST_addr = 32'h500; bus.ST_width = 3'd2; bus.ST_data = 32'h77;
    wait_grant(ok);
    Sys_rst = 1'b1; bus.MCA_w_en = 1'b1;
    @(negedge Sys_clk);
    bus.MCA_w_en = 1'b0;
    chk("t5_st_done", 64'(bus.ST_done), 64'd0);
    chk("t5_amc_en", 64'(bus.AMC_en), 64'd0);
    Sys_rst = 1'b0; bus.ST_en = 1'b0;
    @(negedge Sys_clk);
    chk("t5_still_idle", 64'(bus.AMC_en), 64'd0);
    bus.LD_en = 1'b1; bus.LD_addr = 32'h110; bus.LD_width = 3'd1;
    serve(2'd1, 32'h110, 3'd1, 32'h0, 64'h0000_0000_0BAD_F00D, 1'b1);
    bus.LD_en = 1'b0;

    // 6: Sys_rdy low during GRANT, then low again while the done is pending
    @(negedge Sys_clk);
    bus.LD_en = 1'b1; bus.LD_addr = 32'h600; bus.LD_width = 3'd0;
    wait_grant(ok);
    Sys_rdy = 1'b0;
    repeat (5) begin
      @(negedge Sys_clk);
      chk("t6_frozen_en", 64'(bus.AMC_en), 64'd1);
      chk("t6_frozen_addr", 64'(bus.AMC_addr), 64'h600);
    end
    Sys_rdy = 1'b1;
    e.who = 2'd1; e.val = 64'h0000_0000_1122_3344;
    exp_q.push_back(e);
    bus.MCA_data = 32'h1122_3344; bus.MCA_r_en = 1'b1;
    @(posedge Sys_clk);
    #1;
    bus.MCA_r_en = 1'b0;
    Sys_rdy = 1'b0;
    repeat (5) begin
      @(negedge Sys_clk);
      chk("t6_done_held", 64'(bus.LD_done), 64'd0);
      chk("t6_amc_off", 64'(bus.AMC_en), 64'd0);
      chk("t6_ld_data", 64'(bus.LD_data), 64'h1122_3344);
    end
    @(posedge Sys_clk);
    #1;
    Sys_rdy = 1'b1;
    @(negedge Sys_clk);
    chk("t6_done_once", 64'(bus.LD_done), 64'd1);
    bus.LD_en = 1'b0;
    repeat (3) @(negedge Sys_clk);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
